tree_accum: RTL and testbench

TREE_ACCUM -- requirements
Module: tree_accum

---
 rtl/tree_accum.sv | 95 +++++++++
 tb/tb_tree_accum.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tree_accum.sv
// tree_accum: sums frame_len adder-tree results per job, tracking launches with a
// latency-matched tag pipeline; sticky overflow on accumulator wrap.
module tree_accum #(
    parameter int DW    = 32,
    parameter int LAT   = 6,
    parameter int ACC_W = 48,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             launch,
    output logic             launch_ready,
    input  logic [DW-1:0]    tree_sum,
    output logic [ACC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overflow
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic             rstn_meta_q, rstn_sync_q;
    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, issued_q, issued_d, received_q, received_d, received_inc;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d, take;
    logic [LAT-1:0]   tag_q;
    logic [ACC_W:0]   sum_w;

    // reset asserts immediately, releases two edges after rst_n rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {rstn_sync_q, rstn_meta_q} <= 2'b00;
        else        {rstn_sync_q, rstn_meta_q} <= {rstn_meta_q, 1'b1};
    end

    assign launch_ready = (state_q == S_ACCUM) && (issued_q < len_q);
    assign take         = launch && launch_ready;
    assign received_inc = received_q + 1'b1;
    assign sum_w        = {1'b0, acc_q} + {{(ACC_W + 1 - DW){1'b0}}, tree_sum};
    assign out_valid    = state_q == S_DONE;
    assign out_data     = acc_q;
    assign busy         = state_q != S_IDLE;
    assign overflow     = ovf_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        received_d = received_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        if (state_q == S_IDLE && start) begin
            len_d      = frame_len;
            issued_d   = '0;
            received_d = '0;
            acc_d      = '0;
            ovf_d      = 1'b0;
            state_d    = (frame_len == '0) ? S_DONE : S_ACCUM;
        end
        if (state_q == S_ACCUM) begin
            if (take) issued_d = issued_q + 1'b1;
            if (tag_q[LAT-1]) begin
                acc_d      = sum_w[ACC_W-1:0];
                ovf_d      = ovf_q | sum_w[ACC_W];
                received_d = received_inc;
                if (received_inc == len_q) state_d = S_DONE;
            end
        end
        if (state_q == S_DONE && out_ready) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rstn_sync_q) begin
        if (!rstn_sync_q) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            received_q <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            tag_q      <= (tag_q << 1) | LAT'(take);
        end
    end
endmodule

// File: tb/tb_tree_accum.sv
// tb_tree_accum: table-driven jobs against a delay-line tree model, scoreboarded results.
module tb_tree_accum;
    localparam int DW = 32, LAT = 6, ACC_W = 36, LEN_W = 16;

    typedef struct {
        int               len;
        int               n;
        logic [31:0]      v0;
        logic [31:0]      step;
        logic [ACC_W-1:0] exp_data;
        logic             exp_ovf;
        int               hold;
        logic             poke;
    } vec_t;

    typedef struct {
        logic [ACC_W-1:0] data;
        logic             ovf;
    } res_t;

    logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, launch = 1'b0, out_ready = 1'b0;
    logic [LEN_W-1:0] frame_len = '0;
    logic [DW-1:0]    din = '0, tree_sum;
    logic [DW-1:0]    pipe [LAT];
    logic             launch_ready, out_valid, busy, overflow;
    logic [ACC_W-1:0] out_data;
    longint           cyc = 0;
    int               checks = 0, errors = 0;
    res_t             exp_q[$];
    vec_t             vecs[7];

    tree_accum #(.DW(DW), .LAT(LAT), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
        .launch(launch), .launch_ready(launch_ready), .tree_sum(tree_sum),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // upstream adder tree: whatever din is presented appears on tree_sum LAT cycles later
    always @(posedge clk) begin
        cyc <= cyc + 1;
        pipe[0] <= din;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign tree_sum = pipe[LAT-1];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v);
        int     acc_n;
        longint last_c;
        res_t   e;
        @(negedge clk);
        start = 1'b1;
        frame_len = LEN_W'(v.len);
        exp_q.push_back('{v.exp_data, v.exp_ovf});
        last_c = cyc;
        @(negedge clk);
        start = 1'b0;
        frame_len = LEN_W'($urandom);
        chk("ovf_clear_on_start", {63'd0, overflow}, 64'd0);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        acc_n = 0;
        for (int i = 0; i < v.n; i++) begin
            launch = 1'b1;
            din = v.v0 + i * v.step;
            if (launch_ready) begin
                acc_n++;
                last_c = cyc;
            end
            @(negedge clk);
        end
        launch = 1'b0;
        din = $urandom;
        chk("accept_count", 64'(acc_n), 64'((v.len < v.n) ? v.len : v.n));
        chk("ready_low_after_frame", {63'd0, launch_ready}, 64'd0);
        for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout got 0 want 1");
            return;
        end
        chk("done_latency", 64'(cyc - last_c), (v.len == 0) ? 64'd1 : 64'(LAT + 1));
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty got 0 want 1");
            return;
        end
        e = exp_q.pop_front();
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("overflow", {63'd0, overflow}, {63'd0, e.ovf});
        for (int h = 0; h < v.hold; h++) begin
            start = v.poke;
            @(negedge clk);
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_data", 64'(out_data), 64'(e.data));
            chk("hold_ovf", {63'd0, overflow}, {63'd0, e.ovf});
        end
        out_ready = 1'b1;
        start = v.poke;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", {63'd0, out_valid}, 64'd0);
        chk("idle_after_handshake", {63'd0, busy}, 64'd0);
        start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4, 4, 32'd10, 32'd10, 36'd100, 1'b0, 0, 1'b0};
        vecs[1] = '{3, 6, 32'd5, 32'd1, 36'd18, 1'b0, 2, 1'b0};
        vecs[2] = '{5, 5, 32'd100, 32'd100, 36'd1500, 1'b0, 0, 1'b0};
        vecs[3] = '{18, 18, 32'hFFFF_FFFF, 32'd0, 36'h1_FFFF_FFEE, 1'b1, 2, 1'b0};
        vecs[4] = '{2, 2, 32'd1, 32'd1, 36'd3, 1'b0, 0, 1'b0};
        vecs[5] = '{0, 0, 32'd0, 32'd0, 36'd0, 1'b0, 5, 1'b1};
        vecs[6] = '{1, 3, 32'd9, 32'd1, 36'd9, 1'b0, 1, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        chk("rst_ready", {63'd0, launch_ready}, 64'd0);
        rst_n = 1'b1;
        launch = 1'b1;
        din = 32'd12345;
        repeat (4) @(negedge clk);
        chk("idle_ready_low", {63'd0, launch_ready}, 64'd0);
        launch = 1'b0;
        repeat (LAT) @(negedge clk);

        for (int j = 0; j < 7; j++) run_job(vecs[j]);

        @(negedge clk);
        start = 1'b1;
        frame_len = 16'd4;
        exp_q.push_back('{36'd10000, 1'b0});
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            launch = 1'b1;
            din = 32'd1000 * (i + 1);
            @(negedge clk);
        end
        launch = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midjob_rst_busy", {63'd0, busy}, 64'd0);
        chk("midjob_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("midjob_rst_data", 64'(out_data), 64'd0);
        chk("midjob_rst_ovf", {63'd0, overflow}, 64'd0);
        chk("midjob_rst_ready", {63'd0, launch_ready}, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_job('{1, 1, 32'd7, 32'd0, 36'd7, 1'b0, 0, 1'b0});

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
